// File: rtl/axis_spm_dac_serializer_if.sv
// axis_spm_dac_serializer_if: continuous AXI-Stream data/valid bundle (sources never stall, so no tready)
interface axis_spm_dac_serializer_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  modport master (output tdata, tvalid);
  modport slave  (input  tdata, tvalid);
endinterface

// File: rtl/axis_spm_dac_serializer.sv
// axis_spm_dac_serializer: snapshots X/Y/Z/U Q31 streams and shifts them to four DAC lanes sharing SCLK/SYNC_n/LDAC_n; define DAC_ROUND_EN for round-to-nearest conversion
module axis_spm_dac_serializer #(
  parameter int                  SAXIS_TDATA_WIDTH = 32,
  parameter int                  DAC_BITS          = 20,
  parameter int                  CMD_BITS          = 4,
  parameter logic [CMD_BITS-1:0] CMD_WRITE         = CMD_BITS'(1),
  parameter int                  SCLK_DIV          = 2,
  parameter int                  SYNC_GAP          = 4,
  parameter int                  LDAC_W            = 2
) (
  input  logic                             a_clk,
  input  logic                             a_resetn,
  input  logic                             enable,
  axis_spm_dac_serializer_if.slave         s_axis_x,
  axis_spm_dac_serializer_if.slave         s_axis_y,
  axis_spm_dac_serializer_if.slave         s_axis_z,
  axis_spm_dac_serializer_if.slave         s_axis_u,
  output logic                             dac_sclk,
  output logic                             dac_sync_n,
  output logic [3:0]                       dac_sdo,
  output logic                             dac_ldac_n,
  output logic                             busy,
  output logic [31:0]                      frame_count,
  output logic [4*SAXIS_TDATA_WIDTH-1:0]   m_axis_dacmon_tdata,
  output logic                             m_axis_dacmon_tvalid
);
  localparam int W = SAXIS_TDATA_WIDTH;
  localparam int FB = CMD_BITS + DAC_BITS;
  localparam int SH = W - DAC_BITS;
  localparam int CNT_MAX = (2*SCLK_DIV > SYNC_GAP) ? ((2*SCLK_DIV > LDAC_W) ? 2*SCLK_DIV : LDAC_W)
                                                   : ((SYNC_GAP > LDAC_W) ? SYNC_GAP : LDAC_W);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(FB);
  localparam logic signed [W:0] CMAX = $signed({{(SH+2){1'b0}}, {(DAC_BITS-1){1'b1}}});
  localparam logic signed [W:0] CMIN = ~CMAX;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LDAC} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DAC_BITS-1:0]     code_q [4];
  logic [DAC_BITS-1:0]     code_d [4];
  logic [FB-1:0]           sh_q [4];
  logic [FB-1:0]           sh_d [4];
  logic                    sclk_q, sclk_d, sync_n_q, sync_n_d, ldac_n_q, ldac_n_d, busy_q, busy_d, mv_q, mv_d;
  logic [31:0]             fc_q, fc_d;
  logic [4*W-1:0]          mon_q, mon_d;
  logic [W-1:0]            din [4];
  logic                    go;

  assign din = '{s_axis_x.tdata, s_axis_y.tdata, s_axis_z.tdata, s_axis_u.tdata};
  assign go = enable & s_axis_x.tvalid & s_axis_y.tvalid & s_axis_z.tvalid & s_axis_u.tvalid;

  // Sum is one bit wider than the input so the rounding offset can never wrap before saturation
  function automatic logic [DAC_BITS-1:0] conv(input logic [W-1:0] d);
    logic signed [W:0] s;
    logic signed [W:0] t;
`ifdef DAC_ROUND_EN
    s = $signed({d[W-1], d}) + $signed((W+1)'(1) << (SH-1));
`else
    s = $signed({d[W-1], d});
`endif
    t = s >>> SH;
    return (t > CMAX) ? CMAX[DAC_BITS-1:0] : (t < CMIN) ? CMIN[DAC_BITS-1:0] : t[DAC_BITS-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    sh_d    = sh_q;
    fc_d    = fc_q;
    mon_d   = mon_q;
    mv_d    = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = LOAD;
        for (int i = 0; i < 4; i++) begin
          code_d[i] = conv(din[i]);
          sh_d[i]   = {CMD_WRITE, conv(din[i])};
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = BW'(FB-1);
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // Advance data one cycle after SCLK falls, keeping hold time at the DAC
        if (cnt_q == CW'(SCLK_DIV))
          for (int i = 0; i < 4; i++) sh_d[i] = sh_q[i] << 1;
        if (cnt_q == CW'(2*SCLK_DIV-1)) begin
          cnt_d = '0;
          bit_d = bit_q - 1'b1;
          if (bit_q == '0) state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SYNC_GAP-1)) begin
          cnt_d   = '0;
          state_d = LDAC;
        end
      end
      LDAC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(LDAC_W-1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          fc_d    = fc_q + 1'b1;
          mv_d    = 1'b1;
          for (int i = 0; i < 4; i++) mon_d[i*W +: W] = {{SH{code_q[i][DAC_BITS-1]}}, code_q[i]};
        end
      end
      default: state_d = IDLE;
    endcase
    sclk_d   = (state_d == SHIFT) && (cnt_d < CW'(SCLK_DIV));
    sync_n_d = !(state_d == LOAD || state_d == SHIFT);
    ldac_n_d = state_d != LDAC;
    busy_d   = state_d != IDLE;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '{default: '0};
      sh_q     <= '{default: '0};
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      fc_q     <= '0;
      mon_q    <= '0;
      mv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      fc_q     <= fc_d;
      mon_q    <= mon_d;
      mv_q     <= mv_d;
    end
  end

  assign dac_sclk             = sclk_q;
  assign dac_sync_n           = sync_n_q;
  assign dac_ldac_n           = ldac_n_q;
  assign busy                 = busy_q;
  assign frame_count          = fc_q;
  assign m_axis_dacmon_tdata  = mon_q;
  assign m_axis_dacmon_tvalid = mv_q;
  assign dac_sdo = sync_n_q ? 4'b0 : {sh_q[3][FB-1], sh_q[2][FB-1], sh_q[1][FB-1], sh_q[0][FB-1]};
endmodule

// File: tb/tb_axis_spm_dac_serializer.sv
// tb_axis_spm_dac_serializer: random and corner frames checked against a frame-level arithmetic model of the DAC serializer
module tb_axis_spm_dac_serializer;
  logic         a_clk = 1'b0;
  logic         a_resetn = 1'b0;
  logic         enable = 1'b0;
  logic         dac_sclk, dac_sync_n, dac_ldac_n, busy, dacmon_tvalid;
  logic [3:0]   dac_sdo;
  logic [31:0]  frame_count;
  logic [127:0] dacmon_tdata;
  logic [31:0]  exp_fc = '0;
  int           n_tests = 0;
  int           n_fail = 0;

  axis_spm_dac_serializer_if #(.TDATA_WIDTH(32)) sx (), sy (), sz (), su ();

  always #5 a_clk = ~a_clk;

  axis_spm_dac_serializer dut (
    .a_clk                (a_clk),
    .a_resetn             (a_resetn),
    .enable               (enable),
    .s_axis_x             (sx),
    .s_axis_y             (sy),
    .s_axis_z             (sz),
    .s_axis_u             (su),
    .dac_sclk             (dac_sclk),
    .dac_sync_n           (dac_sync_n),
    .dac_sdo              (dac_sdo),
    .dac_ldac_n           (dac_ldac_n),
    .busy                 (busy),
    .frame_count          (frame_count),
    .m_axis_dacmon_tdata  (dacmon_tdata),
    .m_axis_dacmon_tvalid (dacmon_tvalid)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // DAC code = floor(value / 2^12), optionally rounded to nearest, clamped to 20-bit signed range
  function automatic longint code_of(input logic [31:0] d);
    longint v, q;
    v = longint'($signed(d));
`ifdef DAC_ROUND_EN
    v = v + 2048;
`endif
    q = v / 4096;
    if (v % 4096 < 0) q = q - 1;
    if (q > 524287) q = 524287;
    if (q < -524288) q = -524288;
    return q;
  endfunction

  function automatic logic [23:0] word_of(input logic [31:0] d);
    return {4'b0001, 20'(code_of(d))};
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic [31:0] u);
    sx.tdata = x; sy.tdata = y; sz.tdata = z; su.tdata = u;
    sx.tvalid = 1'b1; sy.tvalid = 1'b1; sz.tvalid = 1'b1; su.tvalid = 1'b1;
  endtask

  // Called at a negedge with the block idle or in its IDLE cycle; returns at the sample where LDAC_n has risen
  task automatic do_frame(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic [31:0] u,
                          input int drop_bit, input bit scramble);
    logic [23:0] w [4];
    logic [31:0] v [4];
    logic [3:0]  prev_sdo = '0;
    logic        prev_sclk = 1'b0;
    int wait_c = 0, cyc = 0, falls = 0, ldac_low = 0, sync_low = 0, idle_busy = 0, early_mv = 0;
    bit done = 1'b0;
    v = '{x, y, z, u};
    w = '{default: '0};
    drive(x, y, z, u);
    enable = 1'b1;
    while (dac_sync_n && wait_c < 300) begin
      @(negedge a_clk);
      wait_c++;
    end
    check("start_wait", wait_c, 1);
    while (!done && cyc < 300) begin
      if (prev_sclk && !dac_sclk) begin
        falls++;
        for (int i = 0; i < 4; i++) w[i] = {w[i][22:0], prev_sdo[i]};
        if (falls == drop_bit) enable = 1'b0;
      end
      if (!dac_sync_n) sync_low++;
      if (!dac_ldac_n) ldac_low++;
      if (dac_ldac_n && ldac_low > 0) done = 1'b1;
      else begin
        if (!busy) idle_busy++;
        if (dacmon_tvalid) early_mv++;
        if (scramble) sx.tdata = $urandom;
        prev_sclk = dac_sclk;
        prev_sdo = dac_sdo;
        @(negedge a_clk);
        cyc++;
      end
    end
    exp_fc++;
    check("sclk_falls", falls, 24);
    check("ldac_low", ldac_low, 2);
    check("sync_low", sync_low, 97);
    check("latency", cyc, 103);
    check("busy_frame", idle_busy, 0);
    check("mv_early", early_mv, 0);
    check("mv_pulse", dacmon_tvalid, 1);
    check("busy_end", busy, 0);
    check("frame_count", frame_count, exp_fc);
    for (int i = 0; i < 4; i++) check($sformatf("lane%0d", i), w[i], word_of(v[i]));
    check("dacmon", dacmon_tdata, {32'(code_of(u)), 32'(code_of(z)), 32'(code_of(y)), 32'(code_of(x))});
  endtask

  task automatic idle_check(input string tag, input int n);
    int starts = 0;
    repeat (n) begin
      @(negedge a_clk);
      if (!dac_sync_n || busy) starts++;
    end
    check(tag, starts, 0);
    check({tag, "_fc"}, frame_count, exp_fc);
  endtask

  task automatic reset_mid_frame(input int at_bit);
    int falls = 0, cyc = 0, bad_ldac = 0, bad_mv = 0, bad_sync = 0;
    logic prev_sclk = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom);
    enable = 1'b1;
    while (falls < at_bit && cyc < 400) begin
      @(negedge a_clk);
      cyc++;
      if (prev_sclk && !dac_sclk) falls++;
      prev_sclk = dac_sclk;
    end
    check("rst_reach", falls, at_bit);
    a_resetn = 1'b0;
    enable = 1'b0;
    #1;
    check("abort_sync", dac_sync_n, 1);
    check("abort_sclk", dac_sclk, 0);
    check("abort_ldac", dac_ldac_n, 1);
    check("abort_sdo", dac_sdo, 0);
    check("abort_busy", busy, 0);
    check("abort_fc", frame_count, 0);
    check("abort_mv", dacmon_tvalid, 0);
    check("abort_mon", dacmon_tdata, 0);
    exp_fc = '0;
    repeat (4) @(negedge a_clk);
    a_resetn = 1'b1;
    repeat (150) begin
      @(negedge a_clk);
      if (!dac_ldac_n) bad_ldac++;
      if (dacmon_tvalid) bad_mv++;
      if (!dac_sync_n) bad_sync++;
    end
    check("post_rst_ldac", bad_ldac, 0);
    check("post_rst_mv", bad_mv, 0);
    check("post_rst_sync", bad_sync, 0);
    check("post_rst_fc", frame_count, exp_fc);
  endtask

  initial begin
    drive(32'h40000000, 32'hC0000000, 32'h00000000, 32'h00001000);
    enable = 1'b1;
    repeat (3) @(negedge a_clk);
    check("rst_sclk", dac_sclk, 0);
    check("rst_sync", dac_sync_n, 1);
    check("rst_ldac", dac_ldac_n, 1);
    check("rst_sdo", dac_sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    check("rst_mon", dacmon_tdata, 0);
    check("rst_mv", dacmon_tvalid, 0);
    a_resetn = 1'b1;
    do_frame(32'h40000000, 32'hC0000000, 32'h00000000, 32'h00001000, -1, 1'b0);
    do_frame(32'h00000FFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    do_frame(32'h00000800, 32'h000007FF, 32'hFFFFF800, 32'h7FFFF800, -1, 1'b0);
    repeat (6) do_frame($urandom, $urandom, $urandom, $urandom, -1, 1'b0);
    do_frame($urandom, $urandom, $urandom, $urandom, -1, 1'b1);
    do_frame($urandom, $urandom, $urandom, $urandom, 10, 1'b0);
    idle_check("idle_after_drop", 200);
    for (int l = 0; l < 4; l++) begin
      drive($urandom, $urandom, $urandom, $urandom);
      sx.tvalid = (l != 0);
      sy.tvalid = (l != 1);
      sz.tvalid = (l != 2);
      su.tvalid = (l != 3);
      enable = 1'b1;
      idle_check($sformatf("tvalid%0d_low", l), 150);
      enable = 1'b0;
    end
    reset_mid_frame(12);
    do_frame($urandom, $urandom, $urandom, $urandom, 10, 1'b0);
    idle_check("idle_end", 50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_spm_dac_serializer.md
Name: axis_spm_dac_serializer

Overview:
- Downstream stage of the SPM control block. Consumes the four absolute output streams: X (M_AXIS1), Y (M_AXIS2), Z (M_AXIS3) and Bias U (M_AXIS4), all 32-bit signed Q31.
- Converts each stream to a DAC code and shifts all four out simultaneously on four parallel SPI data lanes. The lanes share SCLK, SYNC_n and LDAC_n, so all four outputs update together.
- Runs free at the maximum frame rate while enabled and gives a coherent X/Y/Z/U snapshot per frame.

Parameters:
SAXIS_TDATA_WIDTH, 32, input stream width (Q31 signed)
DAC_BITS, 20, DAC code width (two's complement)
CMD_BITS, 4, command prefix width; frame length = CMD_BITS+DAC_BITS
CMD_WRITE, 4'b0001, command prefix for "write DAC register"
SCLK_DIV, 2, a_clk cycles per SCLK half-period (>=1)
SYNC_GAP, 4, a_clk cycles SYNC_n held high between frames (>=1)
LDAC_W, 2, a_clk cycles LDAC_n held low (>=1)

Ports:
a_clk  in  1  system clock
a_resetn  in  1  asynchronous active-low reset
enable  in  1  run frames while high
S_AXIS_X_tdata  in  32  X Q31; S_AXIS_X_tvalid in 1
S_AXIS_Y_tdata  in  32  Y Q31; S_AXIS_Y_tvalid in 1
S_AXIS_Z_tdata  in  32  Z Q31; S_AXIS_Z_tvalid in 1
S_AXIS_U_tdata  in  32  U Q31; S_AXIS_U_tvalid in 1
dac_sclk  out  1  SPI clock, idles low
dac_sync_n  out  1  frame select, active low
dac_sdo  out  4  serial data, lane0=X, lane1=Y, lane2=Z, lane3=U, MSB first
dac_ldac_n  out  1  DAC load strobe, active low
busy  out  1  high from LOAD through end of LDAC
frame_count  out  32  completed frames, wraps
M_AXIS_DACMON_tdata  out  128  last transmitted codes {U,Z,Y,X}, each sign-extended to 32
M_AXIS_DACMON_tvalid  out  1  one-cycle pulse when LDAC_n rises

Behaviour:
Reset (async assert, sync release) sets:
- state IDLE; dac_sclk=0, dac_sync_n=1, dac_ldac_n=1, dac_sdo=0
- busy=0, frame_count=0, DACMON tdata=0, DACMON tvalid=0

FSM states:
- IDLE: go to LOAD when enable=1 and all four tvalid=1; otherwise stay.
- LOAD (1 cycle):
  - Capture all four tdata in the same cycle.
  - Convert each to a code and build frame = {CMD_WRITE, code}.
  - Drive dac_sync_n=0 and dac_sdo = frame MSBs; bit counter = CMD_BITS+DAC_BITS-1.
  - Go to SHIFT.
- SHIFT, per bit:
  - SCLK_DIV cycles with sclk high, then SCLK_DIV cycles with sclk low.
  - On the sclk high->low transition the DAC samples the bit.
  - The next bit is presented in the cycle after the falling edge.
  - After the falling edge of bit 0: sclk stays low, dac_sync_n=1, go to GAP.
- GAP: SYNC_GAP cycles, then go to LDAC.
- LDAC: dac_ldac_n=0 for LDAC_W cycles. On release:
  - frame_count+1
  - DACMON tdata updates, DACMON tvalid pulses
  - go to IDLE

Timing:
- Frame period = 1 + (CMD_BITS+DAC_BITS)*2*SCLK_DIV + SYNC_GAP + LDAC_W + 1 (IDLE) cycles; default 1+96+4+2+1 = 104 cycles.
- Latency from capture to LDAC_n rise = 1 + 96 + 4 + 2 = 103 cycles.

Conversion (two's complement throughout):
- Without rounding: code = tdata >>> (32-DAC_BITS), i.e. truncation toward -inf.
- Saturation: codes beyond ±(2^(DAC_BITS-1)) clamp to 0x7FFFF / 0x80000 (DAC_BITS=20).

Boundary conditions:
- enable deasserted mid-frame: the frame completes through LDAC, then the block stays in IDLE.
- Any tvalid low in IDLE: no frame starts.
- Input changes during SHIFT are ignored; only the snapshot captured in LOAD is sent.
- Reset mid-frame: all outputs go to their reset values immediately. A partial frame is aborted (SYNC_n rises) and no LDAC is issued.
- frame_count wraps 0xFFFFFFFF -> 0.

Optional Feature:
Macro DAC_ROUND_EN.
- Defined: before the shift, add 2^(31-DAC_BITS) (0x800 for 20 bits) as a 33-bit signed sum, then shift arithmetically and saturate. Positive overflow, e.g. 0x7FFFFFFF, saturates to 0x7FFFF.
- Undefined: pure arithmetic-shift truncation, no adder. 0x7FFFFFFF gives 0x7FFFF directly.

Test Plan:
- Reset with enable=1 and all tvalid=1, then release -> first SYNC_n fall 1 cycle after release; 24 SCLK falling edges; LDAC_n low 2 cycles; frame_count=1 after 104 cycles.
- X=0x40000000, Y=0xC0000000, Z=0, U=0x00001000 -> serial words on lanes 0..3: 0x140000, 0x1C0000, 0x100000, 0x100001.
- X=0x00000FFF: DAC_ROUND_EN defined -> lane0 code 0x00001; undefined -> 0x00000. X=0x7FFFFFFF with DAC_ROUND_EN -> 0x7FFFF (saturated, no wrap).
- Drop enable at bit 10 of the shift -> frame completes with LDAC; IDLE afterwards; frame_count +1 only.
- Assert a_resetn low at bit 12 -> SYNC_n=1, SCLK=0, LDAC_n stays 1, frame_count=0, DACMON tvalid never pulses.
- Change X tdata every cycle during SHIFT -> transmitted code equals the value captured in LOAD; DACMON reports that code at the LDAC_n rise.
